cell_share_sequencer: RTL and testbench

- Multi-cycle sequencer for the battery current-sharing computation.
- Drives ONE shared FP32 arithmetic unit through an op request/acknowledge handshake, instead of instantiating reciprocal, divider and multiplier logic per cell.
- Per cell k: addend_k = (mode ? 1/soc_k : soc_k); den = (a0+a1)+(a2+a3); i_k = (addend_k/den)*I.
- Sits between the SOC/current inputs and the shared FP unit; replaces the combinational datapath for area-constrained builds.

---
 rtl/cell_share_if.sv | 16 +
 rtl/cell_share_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_cell_share_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_share_if.sv
// Operation bus between the current-sharing sequencer (master) and the shared
// FP32 arithmetic unit (slave).
interface cell_share_if;
    // op_req rises with op_code/op_a/op_b valid and holds them until the cycle
    // op_ack is seen with it; op_result is taken on that cycle, and op_ack is
    // ignored whenever op_req is low.
    logic        op_req;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ack;
    logic [31:0] op_result;

    modport master (output op_req, op_code, op_a, op_b, input op_ack, op_result);
    modport slave  (input op_req, op_code, op_a, op_b, output op_ack, op_result);
endinterface

// File: rtl/cell_share_sequencer.sv
// Per-cell current sharing i_k = (addend_k / sum(addend)) * I on one shared FP unit.
// Optional ack watchdog: define CELL_SHARE_ACK_TIMEOUT_EN.
module cell_share_sequencer #(
    parameter int ACK_WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  soc1,
    input  logic [31:0]  soc2,
    input  logic [31:0]  soc3,
    input  logic [31:0]  soc4,
    input  logic [31:0]  i_in,
    output logic         busy,
    output logic         done,
    output logic         den_err,
    output logic [2:0]   dbg_state,
    cell_share_if.master fp,
    output logic [31:0]  i1,
    output logic [31:0]  i2,
    output logic [31:0]  i3,
    output logic [31:0]  i4
`ifdef CELL_SHARE_ACK_TIMEOUT_EN
    ,
    output logic         timeout_err
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_RECIP, S_SUM, S_DIV, S_MUL, S_FIN} state_t;
    localparam logic [1:0] OP_ADD = 2'b00, OP_MUL = 2'b01, OP_DIV = 2'b10, OP_RECIP = 2'b11;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic        r_gap, w_gap_nxt;
    logic        w_fin_zero, w_den_zero, w_timeout, w_capture, w_start;
    logic [31:0] r_soc [4];
    logic [31:0] r_add [4];
    logic [31:0] r_q   [4];
    logic [31:0] r_r   [4];
    logic [31:0] r_iin, r_t0, r_t1, r_den;
    logic [3:0]  w_in_nz, w_soc_nz;
    logic [2:0]  w_pick_in, w_pick_next;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] pick_nz(input logic [3:0] mask, input int from);
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && k >= from) res = {1'b1, 2'(k)};
        end
        return res;
    endfunction

    assign w_in_nz     = {|soc4[30:0], |soc3[30:0], |soc2[30:0], |soc1[30:0]};
    assign w_soc_nz    = {|r_soc[3][30:0], |r_soc[2][30:0], |r_soc[1][30:0], |r_soc[0][30:0]};
    assign w_pick_in   = pick_nz(w_in_nz, 0);
    assign w_pick_next = pick_nz(w_soc_nz, int'(r_idx) + 1);
    assign w_capture   = fp.op_req && fp.op_ack;
    assign w_start     = (r_state == S_IDLE) && start;

`ifdef CELL_SHARE_ACK_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       w_wait_hit;
    assign w_wait_hit = fp.op_req && !fp.op_ack && (r_wait == 8'(ACK_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            r_wait <= (fp.op_req && !fp.op_ack && !w_wait_hit) ? r_wait + 8'd1 : 8'd0;
            if (w_start)        timeout_err <= 1'b0;
            else if (w_timeout) timeout_err <= 1'b1;
        end
    end
`else
    logic w_wait_hit;
    assign w_wait_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Every op ends with one request-free gap cycle; index/state advance at its end.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = 1'b0;
        w_fin_zero  = 1'b0;
        w_den_zero  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_idx_nxt = 2'd0;
                if (i_in[30:0] == 31'd0) begin
                    w_state_nxt = S_FIN;
                    w_fin_zero  = 1'b1;
                end else if (i_in[31] && w_pick_in[2]) begin
                    w_state_nxt = S_RECIP;
                    w_idx_nxt   = w_pick_in[1:0];
                end else begin
                    w_state_nxt = S_SUM;
                end
            end
            S_RECIP, S_SUM, S_DIV, S_MUL: begin
                if (w_capture) begin
                    w_gap_nxt = 1'b1;
                end else if (w_wait_hit) begin
                    w_state_nxt = S_FIN;
                    w_fin_zero  = 1'b1;
                    w_timeout   = 1'b1;
                end else if (r_gap) begin
                    case (r_state)
                        S_RECIP: begin
                            if (w_pick_next[2]) w_idx_nxt = w_pick_next[1:0];
                            else begin
                                w_state_nxt = S_SUM;
                                w_idx_nxt   = 2'd0;
                            end
                        end
                        S_SUM: begin
                            if (r_idx == 2'd2) begin
                                w_idx_nxt = 2'd0;
                                if (r_den[30:0] == 31'd0) begin
                                    w_state_nxt = S_FIN;
                                    w_fin_zero  = 1'b1;
                                    w_den_zero  = 1'b1;
                                end else begin
                                    w_state_nxt = S_DIV;
                                end
                            end else begin
                                w_idx_nxt = r_idx + 2'd1;
                            end
                        end
                        S_DIV: begin
                            w_idx_nxt = r_idx + 2'd1;
                            if (r_idx == 2'd3) w_state_nxt = S_MUL;
                        end
                        default: begin
                            w_idx_nxt = r_idx + 2'd1;
                            if (r_idx == 2'd3) w_state_nxt = S_FIN;
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_FIN);
        dbg_state  = r_state;
        fp.op_req  = (r_state inside {S_RECIP, S_SUM, S_DIV, S_MUL}) && !r_gap;
        fp.op_code = OP_ADD;
        fp.op_a    = 32'h0;
        fp.op_b    = 32'h0;
        if (fp.op_req) begin
            case (r_state)
                S_RECIP: begin
                    fp.op_code = OP_RECIP;
                    fp.op_a    = r_soc[r_idx];
                end
                S_SUM: begin
                    fp.op_code = OP_ADD;
                    fp.op_a    = (r_idx == 2'd0) ? r_add[0] : (r_idx == 2'd1) ? r_add[2] : r_t0;
                    fp.op_b    = (r_idx == 2'd0) ? r_add[1] : (r_idx == 2'd1) ? r_add[3] : r_t1;
                end
                S_DIV: begin
                    fp.op_code = OP_DIV;
                    fp.op_a    = r_add[r_idx];
                    fp.op_b    = r_den;
                end
                default: begin
                    fp.op_code = OP_MUL;
                    fp.op_a    = r_q[r_idx];
                    fp.op_b    = r_iin;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_soc[k] <= 32'h0;
                r_add[k] <= 32'h0;
                r_q[k]   <= 32'h0;
                r_r[k]   <= 32'h0;
            end
            r_iin   <= 32'h0;
            r_t0    <= 32'h0;
            r_t1    <= 32'h0;
            r_den   <= 32'h0;
            i1      <= 32'h0;
            i2      <= 32'h0;
            i3      <= 32'h0;
            i4      <= 32'h0;
            den_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_soc[0] <= soc1;
                r_soc[1] <= soc2;
                r_soc[2] <= soc3;
                r_soc[3] <= soc4;
                r_iin    <= i_in;
                // Reciprocal mode pre-clears addends so zero-SOC cells stay 0 without an op.
                r_add[0] <= i_in[31] ? 32'h0 : soc1;
                r_add[1] <= i_in[31] ? 32'h0 : soc2;
                r_add[2] <= i_in[31] ? 32'h0 : soc3;
                r_add[3] <= i_in[31] ? 32'h0 : soc4;
            end
            if (w_capture) begin
                case (r_state)
                    S_RECIP: r_add[r_idx] <= fp.op_result;
                    S_SUM: begin
                        if (r_idx == 2'd0)      r_t0  <= fp.op_result;
                        else if (r_idx == 2'd1) r_t1  <= fp.op_result;
                        else                    r_den <= fp.op_result;
                    end
                    S_DIV:   r_q[r_idx] <= fp.op_result;
                    S_MUL:   r_r[r_idx] <= fp.op_result;
                    default: ;
                endcase
            end
            if (w_state_nxt == S_FIN && r_state != S_FIN) begin
                i1      <= w_fin_zero ? 32'h0 : r_r[0];
                i2      <= w_fin_zero ? 32'h0 : r_r[1];
                i3      <= w_fin_zero ? 32'h0 : r_r[2];
                i4      <= w_fin_zero ? 32'h0 : r_r[3];
                den_err <= w_den_zero;
            end
        end
    end
endmodule

// File: tb/tb_cell_share_sequencer.sv
// Directed bench for cell_share_sequencer with a real-valued FP unit responder.
module tb_cell_share_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] soc1 = 32'h0, soc2 = 32'h0, soc3 = 32'h0, soc4 = 32'h0, i_in = 32'h0;
    logic        busy, done, den_err;
    logic [2:0]  dbg_state;
    logic [31:0] i1, i2, i3, i4;
`ifdef CELL_SHARE_ACK_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    cell_share_if fp_bus();

    cell_share_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .soc1(soc1), .soc2(soc2), .soc3(soc3), .soc4(soc4), .i_in(i_in),
        .busy(busy), .done(done), .den_err(den_err), .dbg_state(dbg_state),
        .fp(fp_bus.master),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4)
`ifdef CELL_SHARE_ACK_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'b0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int          ke;
        logic [23:0] keep;
        logic [28:0] rem;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'b0};
        ke   = int'(b[62:52]) - 1023 + 127;
        keep = {1'b0, b[51:29]};
        rem  = b[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && keep[0])) keep = keep + 24'd1;
        if (keep[23]) begin
            keep = 24'd0;
            ke++;
        end
        return {b[63], ke[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] fp_model(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            2'b00:   return r2f(f2r(a) + f2r(b));
            2'b01:   return r2f(f2r(a) * f2r(b));
            2'b10:   return r2f(f2r(a) / f2r(b));
            default: return r2f(1.0 / f2r(a));
        endcase
    endfunction

    // FP unit responder: acks after ack_delay extra request cycles.
    int          ack_delay = 0;
    bit          spur_en = 0;
    int          op_cnt [4] = '{0, 0, 0, 0};
    int          stab_bad = 0;
    int          req_cycles = 0;
    initial begin
        int          wcnt;
        logic [65:0] held;
        wcnt = 0;
        held = '0;
        fp_bus.op_ack    = 1'b0;
        fp_bus.op_result = 32'h0;
        forever begin
            @(negedge clk);
            if (fp_bus.op_req) begin
                req_cycles++;
                if (wcnt == 0) held = {fp_bus.op_code, fp_bus.op_a, fp_bus.op_b};
                else if (held != {fp_bus.op_code, fp_bus.op_a, fp_bus.op_b}) stab_bad++;
                if (wcnt == ack_delay) begin
                    fp_bus.op_ack    = 1'b1;
                    fp_bus.op_result = fp_model(fp_bus.op_code, fp_bus.op_a, fp_bus.op_b);
                    op_cnt[fp_bus.op_code]++;
                end else begin
                    fp_bus.op_ack = 1'b0;
                end
                wcnt++;
            end else begin
                wcnt             = 0;
                fp_bus.op_ack    = spur_en;
                fp_bus.op_result = 32'hDEADBEEF;
            end
        end
    end

    task automatic run_txn(input logic [31:0] s1, s2, s3, s4, iin, output int cyc, output logic b1);
        @(negedge clk);
        soc1 = s1; soc2 = s2; soc3 = s3; soc4 = s4; i_in = iin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        soc1 = 32'h0; soc2 = 32'h0; soc3 = 32'h0; soc4 = 32'h0; i_in = 32'h0;
        b1  = busy;
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e1, e2, e3, e4);
        check_eq({tag, "_i1"}, i1, e1);
        check_eq({tag, "_i2"}, i2, e2);
        check_eq({tag, "_i3"}, i3, e3);
        check_eq({tag, "_i4"}, i4, e4);
    endtask

    task automatic check_near(input string tag, input logic [31:0] got, input real e);
        real o, tol;
        logic close;
        o     = f2r(got);
        tol   = ((e < 0.0) ? -e : e) * 1.0e-5 + 1.0e-9;
        close = ((o - e) <= tol) && ((e - o) <= tol);
        check_eq(tag, {31'b0, close}, 32'd1);
        if (!close) $display("  %s value %f target %f", tag, o, e);
    endtask

    task automatic check_ops(input string tag, input int c0[4], input int ea, em, ed, er);
        check_eq({tag, "_n_add"},   op_cnt[0] - c0[0], ea);
        check_eq({tag, "_n_mul"},   op_cnt[1] - c0[1], em);
        check_eq({tag, "_n_div"},   op_cnt[2] - c0[2], ed);
        check_eq({tag, "_n_recip"}, op_cnt[3] - c0[3], er);
    endtask

    localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000, F4 = 32'h40800000;

    initial begin
        int   cyc, w, c0[4], rq0, sb0;
        logic b1;
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_op_req", fp_bus.op_req, 0);
        check_eq("rst_op_code", fp_bus.op_code, 0);
        check_eq("rst_op_a", fp_bus.op_a, 0);
        check_eq("rst_op_b", fp_bus.op_b, 0);
        check_eq("rst_den_err", den_err, 0);
        check_outs("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Direct mode
        c0 = op_cnt;
        run_txn(F1, F2, F3, F4, 32'h41200000, cyc, b1);
        check_eq("m0_busy_c1", b1, 1);
        check_eq("m0_done_cyc", cyc, 23);
        check_outs("m0", F1, F2, F3, F4);
        check_ops("m0", c0, 3, 4, 4, 0);
        check_eq("m0_den_err", den_err, 0);
        @(negedge clk);
        check_eq("m0_busy_after", busy, 0);
        check_eq("m0_done_after", done, 0);

        // Reciprocal mode
        c0 = op_cnt;
        run_txn(F1, F2, F3, F4, 32'hC1200000, cyc, b1);
        check_eq("m1_done_cyc", cyc, 31);
        check_near("m1_i1", i1, -4.8);
        check_near("m1_i2", i2, -2.4);
        check_near("m1_i3", i3, -1.6);
        check_near("m1_i4", i4, -1.2);
        check_ops("m1", c0, 3, 4, 4, 4);

        // Reciprocal mode with one zero cell: that RECIP is skipped
        c0 = op_cnt;
        run_txn(F1, 32'h0, F2, F4, 32'hBF800000, cyc, b1);
        check_eq("mz_done_cyc", cyc, 29);
        check_near("mz_i1", i1, -1.0 / 1.75);
        check_near("mz_i2", i2, 0.0);
        check_near("mz_i3", i3, -0.5 / 1.75);
        check_near("mz_i4", i4, -0.25 / 1.75);
        check_ops("mz", c0, 3, 4, 4, 3);

        // Reset during MUL, then a clean transaction
        @(negedge clk);
        soc1 = F1; soc2 = F2; soc3 = F3; soc4 = F4; i_in = 32'h41200000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(fp_bus.op_req && fp_bus.op_code == 2'b01) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("rmul_reached", {31'b0, (w < 200)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rmul_op_req", fp_bus.op_req, 0);
        check_eq("rmul_busy", busy, 0);
        check_outs("rmul", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(F1, F2, F3, F4, 32'h41200000, cyc, b1);
        check_eq("rmul_re_cyc", cyc, 23);
        check_outs("rmul_re", F1, F2, F3, F4);

        // Zero denominator, direct mode
        c0 = op_cnt;
        run_txn(32'h0, 32'h0, 32'h0, 32'h0, 32'h40A00000, cyc, b1);
        check_eq("dz0_done_cyc", cyc, 7);
        check_eq("dz0_den_err", den_err, 1);
        check_outs("dz0", 32'h0, 32'h0, 32'h0, 32'h0);
        check_ops("dz0", c0, 3, 0, 0, 0);

        // Zero denominator, reciprocal mode: no RECIP on zero cells
        c0 = op_cnt;
        run_txn(32'h0, 32'h80000000, 32'h0, 32'h0, 32'hC0A00000, cyc, b1);
        check_eq("dz1_done_cyc", cyc, 7);
        check_eq("dz1_den_err", den_err, 1);
        check_ops("dz1", c0, 3, 0, 0, 0);

        // Delayed ack (3 cycles) with spurious acks in the gaps
        ack_delay = 3;
        spur_en   = 1'b1;
        sb0       = stab_bad;
        run_txn(F1, F2, F3, F4, 32'h41200000, cyc, b1);
        check_eq("dly_done_cyc", cyc, 56);
        check_outs("dly", F1, F2, F3, F4);
        check_eq("dly_den_err", den_err, 0);
        check_eq("dly_stable", stab_bad - sb0, 0);
        ack_delay = 0;
        spur_en   = 1'b0;

        // Negative-zero current: no ops, immediate finish
        rq0 = req_cycles;
        run_txn(F1, F2, F3, F4, 32'h80000000, cyc, b1);
        check_eq("nz_done_cyc", cyc, 1);
        check_outs("nz", 32'h0, 32'h0, 32'h0, 32'h0);
        check_eq("nz_den_err", den_err, 0);
        @(negedge clk);
        check_eq("nz_no_req", req_cycles - rq0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
